// File: rtl/pattern_player_pkg.sv
// Shared constants and state encoding for the pattern player.
package pattern_player_pkg;

  localparam int DEF_WIDTH = 31;
  localparam int DEF_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_player_ram.sv
// Simple dual-port pattern store: one write port, one registered read port.
module pattern_ram #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register only is reset; it holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/pattern_player.sv
// Serially loaded pattern memory played back one word per sample strobe.
//   state    | meaning
//   ST_IDLE  | loading / clear allowed, waiting for arm
//   ST_ARMED | waiting for trigger
//   ST_PLAY  | emitting one word per smp_en_i
module pattern_player
  import pattern_player_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_valid_i,
  input  logic             ld_bit_i,
  input  logic             clear_i,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic             smp_en_i,
  input  logic             loop_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW:0]      count_o,
  output logic             ld_err_o
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] wr_word;
  logic [BW-1:0]    bit_cnt_q;
  logic [AW:0]      count_q;
  logic [AW:0]      rd_ptr_q;
  logic             ld_err_q, valid_q, done_q;
  logic             rd_en, play_end, last_word, word_done, wr_en;

  assign last_word = (rd_ptr_q == count_q - (AW+1)'(1));
  assign wr_word   = {shift_q[WIDTH-2:0], ld_bit_i};
  assign word_done = (state_q == ST_IDLE) && !clear_i && ld_valid_i &&
                     (bit_cnt_q == BW'(WIDTH - 1));
  assign wr_en     = word_done && (count_q != (AW+1)'(DEPTH));

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    play_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_i && !clear_i && (count_q != '0)) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort_i)     state_d = ST_IDLE;
        else if (trig_i) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (smp_en_i) begin
          rd_en = 1'b1;
          // loop_i matters only on the strobe that reads the last word
          if (last_word && !loop_i) begin
            state_d  = ST_IDLE;
            play_end = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      ld_err_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= rd_en;
      done_q  <= play_end;

      if (state_q == ST_IDLE) begin
        if (clear_i) begin
          count_q   <= '0;
          bit_cnt_q <= '0;
          ld_err_q  <= 1'b0;
        end else if (ld_valid_i) begin
          shift_q <= wr_word;
          if (word_done) begin
            bit_cnt_q <= '0;
            if (wr_en) count_q  <= count_q + (AW+1)'(1);
            else       ld_err_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
      end else if (ld_valid_i) begin
        ld_err_q <= 1'b1;
      end

      if (state_q == ST_ARMED) rd_ptr_q <= '0;
      else if (rd_en)          rd_ptr_q <= last_word ? '0 : rd_ptr_q + (AW+1)'(1);
    end
  end

  pattern_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (wr_word),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (data_o)
  );

  assign valid_o  = valid_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign count_o  = count_q;
  assign ld_err_o = ld_err_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed table-driven bench for pattern_player (WIDTH 31, DEPTH 64).
module tb_pattern_player;

  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_bit, clear, arm, trig, smp_en, loop_en, abort;
  logic [30:0] data;
  logic        valid, busy, done, ld_err;
  logic [6:0]  count;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] RST = 8'h80, CLR = 8'h40, ARM = 8'h20, TRG = 8'h10;
  localparam logic [7:0] SMP = 8'h08, LP  = 8'h04, ABT = 8'h02, LDV = 8'h01;

  typedef struct packed {
    logic [7:0]  ctl;
    logic        ev;
    logic        ed;
    logic        eb;
    logic [30:0] edata;
    logic [6:0]  ecnt;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  pattern_player dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ld_valid_i (ld_valid),
    .ld_bit_i   (ld_bit),
    .clear_i    (clear),
    .arm_i      (arm),
    .trig_i     (trig),
    .smp_en_i   (smp_en),
    .loop_i     (loop_en),
    .abort_i    (abort),
    .data_o     (data),
    .valid_o    (valid),
    .busy_o     (busy),
    .done_o     (done),
    .count_o    (count),
    .ld_err_o   (ld_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] ctl, input logic ev, input logic ed,
                              input logic eb, input logic [30:0] edata,
                              input logic [6:0] ecnt, input logic eerr);
    vec_t v;
    v.ctl = ctl; v.ev = ev; v.ed = ed; v.eb = eb;
    v.edata = edata; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ctl(input logic [7:0] c);
    rst = c[7]; clear = c[6]; arm = c[5]; trig = c[4];
    smp_en = c[3]; loop_en = c[2]; abort = c[1]; ld_valid = c[0]; ld_bit = c[0];
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      drive_ctl(tbl[i].ctl);
      tick();
      nm = $sformatf("%s[%0d]", tag, i);
      chk({nm, ".valid"}, 32'(valid), 32'(tbl[i].ev));
      chk({nm, ".done"},  32'(done),  32'(tbl[i].ed));
      chk({nm, ".busy"},  32'(busy),  32'(tbl[i].eb));
      chk({nm, ".data"},  32'(data),  32'(tbl[i].edata));
      chk({nm, ".count"}, 32'(count), 32'(tbl[i].ecnt));
      chk({nm, ".err"},   32'(ld_err), 32'(tbl[i].eerr));
    end
    drive_ctl(8'h00);
    tbl.delete();
  endtask

  task automatic load_word(input logic [30:0] w);
    for (int b = 30; b >= 0; b--) begin
      ld_valid = 1'b1;
      ld_bit   = w[b];
      tick();
    end
    ld_valid = 1'b0;
    ld_bit   = 1'b0;
  endtask

  initial begin
    drive_ctl(RST);

    // reset state
    tbl.push_back(mk(RST,  0, 0, 0, 31'h0, 7'd0, 0));
    tbl.push_back(mk(8'h0, 0, 0, 0, 31'h0, 7'd0, 0));
    run_table("reset");

    // three words, strobe every 4th cycle, single shot
    load_word(31'h1);
    load_word(31'h2AAAAAAA);
    load_word(31'h7FFFFFFF);
    tbl.push_back(mk(ARM,  0, 0, 1, 31'h0,        7'd3, 0));
    tbl.push_back(mk(TRG,  0, 0, 1, 31'h0,        7'd3, 0));
    tbl.push_back(mk(SMP,  1, 0, 1, 31'h1,        7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h1,        7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h1,        7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h1,        7'd3, 0));
    tbl.push_back(mk(SMP,  1, 0, 1, 31'h2AAAAAAA, 7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h2AAAAAAA, 7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h2AAAAAAA, 7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 1, 31'h2AAAAAAA, 7'd3, 0));
    tbl.push_back(mk(SMP,  1, 1, 0, 31'h7FFFFFFF, 7'd3, 0));
    tbl.push_back(mk(8'h0, 0, 0, 0, 31'h7FFFFFFF, 7'd3, 0));
    run_table("single");

    // looping two words, then abort racing a strobe
    tbl.push_back(mk(CLR, 0, 0, 0, 31'h7FFFFFFF, 7'd0, 0));
    run_table("clr1");
    load_word(31'h1);
    load_word(31'h2);
    tbl.push_back(mk(ARM,          0, 0, 1, 31'h7FFFFFFF, 7'd2, 0));
    tbl.push_back(mk(TRG,          0, 0, 1, 31'h7FFFFFFF, 7'd2, 0));
    tbl.push_back(mk(SMP|LP,       1, 0, 1, 31'h1,        7'd2, 0));
    tbl.push_back(mk(SMP|LP,       1, 0, 1, 31'h2,        7'd2, 0));
    tbl.push_back(mk(SMP|LP,       1, 0, 1, 31'h1,        7'd2, 0));
    tbl.push_back(mk(SMP|LP,       1, 0, 1, 31'h2,        7'd2, 0));
    tbl.push_back(mk(SMP|LP,       1, 0, 1, 31'h1,        7'd2, 0));
    tbl.push_back(mk(SMP|LP|ABT,   0, 0, 0, 31'h1,        7'd2, 0));
    tbl.push_back(mk(8'h0,         0, 0, 0, 31'h1,        7'd2, 0));
    run_table("loop");

    // arm with empty memory; arm+trig together; strobe ignored while armed
    tbl.push_back(mk(CLR, 0, 0, 0, 31'h1, 7'd0, 0));
    tbl.push_back(mk(ARM, 0, 0, 0, 31'h1, 7'd0, 0));
    run_table("empty");
    load_word(31'h5);
    tbl.push_back(mk(ARM|TRG, 0, 0, 1, 31'h1, 7'd1, 0));
    tbl.push_back(mk(SMP,     0, 0, 1, 31'h1, 7'd1, 0));
    tbl.push_back(mk(TRG,     0, 0, 1, 31'h1, 7'd1, 0));
    tbl.push_back(mk(TRG,     0, 0, 1, 31'h1, 7'd1, 0));
    tbl.push_back(mk(SMP,     1, 1, 0, 31'h5, 7'd1, 0));
    run_table("armtrig");

    // load during play, then reset mid-play
    tbl.push_back(mk(CLR, 0, 0, 0, 31'h5, 7'd0, 0));
    run_table("clr2");
    load_word(31'h11);
    load_word(31'h22);
    tbl.push_back(mk(ARM,  0, 0, 1, 31'h5,  7'd2, 0));
    tbl.push_back(mk(TRG,  0, 0, 1, 31'h5,  7'd2, 0));
    tbl.push_back(mk(SMP,  1, 0, 1, 31'h11, 7'd2, 0));
    tbl.push_back(mk(LDV,  0, 0, 1, 31'h11, 7'd2, 1));
    tbl.push_back(mk(RST,  0, 0, 0, 31'h0,  7'd0, 0));
    tbl.push_back(mk(8'h0, 0, 0, 0, 31'h0,  7'd0, 0));
    run_table("playld");

    // overflow: 65 words into 64-deep memory
    for (int i = 0; i < 64; i++) load_word(31'(100 + i));
    chk("ovf.count64", 32'(count), 32'd64);
    chk("ovf.err0",    32'(ld_err), 32'd0);
    load_word(31'h7777);
    chk("ovf.count_hold", 32'(count), 32'd64);
    chk("ovf.err1",       32'(ld_err), 32'd1);

    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    smp_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("full.valid[%0d]", i), 32'(valid), 32'd1);
      chk($sformatf("full.data[%0d]", i),  32'(data),  32'(100 + i));
      chk($sformatf("full.done[%0d]", i),  32'(done),  32'(i == 63));
      chk($sformatf("full.busy[%0d]", i),  32'(busy),  32'(i != 63));
    end
    smp_en = 1'b0;
    tick();
    chk("full.valid_end", 32'(valid), 32'd0);
    chk("full.data_hold", 32'(data),  32'd163);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr3.count", 32'(count), 32'd0);
    chk("clr3.err",   32'(ld_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 SHALL have parameters: WIDTH, default 31, playback word width; DEPTH, default 64, pattern memory words, power of two; AW = log2(DEPTH), derived.
REQ-002 SHALL have port clk_i  in  1  sole clock, all logic on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ld_valid_i  in  1  serial load bit strobe.
REQ-005 SHALL have port ld_bit_i  in  1  serial load data bit, MSB of each word first.
REQ-006 SHALL have port clear_i  in  1  empty pattern memory (pointer reset only).
REQ-007 SHALL have port arm_i  in  1  request arming.
REQ-008 SHALL have port trig_i  in  1  playback trigger.
REQ-009 SHALL have port smp_en_i  in  1  sample-rate strobe, one output word per strobe.
REQ-010 SHALL have port loop_i  in  1  repeat pattern continuously when high.
REQ-011 SHALL have port abort_i  in  1  stop playback immediately.
REQ-012 SHALL have ports data_o  out  WIDTH  played word; valid_o  out  1  data_o update pulse; busy_o  out  1  state not IDLE; done_o  out  1  end-of-pattern pulse; count_o  out  AW+1  words loaded; ld_err_o  out  1  sticky load error.

Function
REQ-013 SHALL implement states IDLE, ARMED, PLAY; busy_o = (state != IDLE).
REQ-014 SHALL in IDLE shift ld_bit_i into a WIDTH-bit register on each ld_valid_i; on the WIDTH-th bit write the word to mem[count_o] and increment count_o in the same cycle.
REQ-015 SHALL, when count_o = DEPTH, discard completed words, hold count_o, and set ld_err_o.
REQ-016 SHALL ignore ld_valid_i outside IDLE, set ld_err_o, and keep the partial bit counter unchanged.
REQ-017 SHALL on clear_i in IDLE zero count_o, the partial bit counter and ld_err_o; memory contents are not cleared; clear_i outside IDLE is ignored.
REQ-018 SHALL move IDLE->ARMED on arm_i when count_o > 0 and no clear_i the same cycle; arm_i with count_o = 0 is ignored.
REQ-019 SHALL move ARMED->PLAY on trig_i with read pointer 0; trig_i in IDLE or PLAY is ignored; arm_i and trig_i together in IDLE give ARMED only.
REQ-020 SHALL in PLAY, on smp_en_i at cycle n, drive data_o = mem[rd_ptr] and valid_o = 1 at cycle n+1 (one-cycle latency, registered read), then advance rd_ptr.
REQ-021 SHALL on the strobe reading word count_o-1: with loop_i = 1 wrap rd_ptr to 0 and stay in PLAY; with loop_i = 0 return to IDLE, asserting done_o together with valid_o for that final word.
REQ-022 SHALL sample loop_i at the last-word strobe only.
REQ-023 SHALL on abort_i in ARMED or PLAY go to IDLE next cycle, no valid_o and no done_o issued that cycle; abort_i takes priority over smp_en_i and trig_i.
REQ-024 SHALL hold data_o between valid_o pulses and after playback ends.
REQ-025 SHALL issue valid_o and done_o as single-cycle pulses; consecutive smp_en_i cycles give consecutive valid_o pulses.

Reset
REQ-026 SHALL on rst_i: state IDLE, count_o 0, rd_ptr 0, bit counter 0, data_o 0, valid_o 0, done_o 0, ld_err_o 0; memory contents undefined; rst_i mid-PLAY stops output the next cycle.

Structure
REQ-027 SHALL place the state enumeration and default WIDTH/DEPTH constants in a shared package.
REQ-028 SHALL use one sub-module, pattern_ram: simple dual-port, one write port, registered-read port, inferable as block RAM.

Verification
REQ-029 Load 3 words 0x1, 0x2AAAAAAA, 0x7FFFFFFF (93 bits), arm, trig, smp_en_i every 4th cycle -> valid_o 3 times one cycle after each strobe, data in order, done_o with third word, busy_o 0 after.
REQ-030 Load 2 words, loop_i = 1, 5 strobes -> data_o 0x1,0x2,0x1,0x2,0x1, no done_o; abort_i -> IDLE next cycle, no valid_o.
REQ-031 Load 65 words with DEPTH 64 -> count_o 64, ld_err_o 1; clear_i -> count_o 0, ld_err_o 0.
REQ-032 arm_i with count_o 0 -> stays IDLE; arm_i+trig_i same cycle -> ARMED, second trig_i -> PLAY.
REQ-033 ld_valid_i during PLAY -> ld_err_o 1, count_o unchanged; rst_i mid-PLAY -> all outputs 0 next cycle.
